video_timing_gen: RTL
=====================

# video_timing_gen

Raster timing generator and pixel pacer that drives the TMDS encoder/serializer stage: produces hsync, vsync and de and pulls 24-bit RGB pixels from an upstream pixel source (line buffer / FIFO) with a valid/ready handshake. All outputs are registered and mutually aligned, so they connect directly to the encoder's blue/green/red, hsync, vsync and de inputs. Defaults give 1280x720@60 (74.25 MHz pixel clock).

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- pixelclk  in  1  pixel clock; sole clock
- rstin  in  1  synchronous, active-high reset
- en  in  1  run enable; low holds the raster at origin
- pix_data  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  pixel consumed this cycle if pix_valid
- red_dout / green_dout / blue_dout  out  8 each  pixel to encoder
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  data enable
- frame_start  out  1  one-cycle pulse aligned with first active pixel of a frame
- underflow  out  1  sticky: active pixel requested but pix_valid low

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h_cnt (0..H_TOTAL-1), v_cnt (0..V_TOTAL-1), width clog2 of totals.
- en high: h_cnt increments each cycle; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt wraps to 0 at V_TOTAL-1 together with h_cnt wrap.
- en low: both counters forced to 0, pix_ready 0, outputs driven to idle (de 0, syncs inactive, RGB 0) on next edge. Raising en restarts at pixel (0,0).
- active = en && h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), full lines (changes at h_cnt = 0).
- pix_ready = active (combinational from counters). Transfer = pix_ready && pix_valid.
- Active cycle, pix_valid high: pixel registered to outputs. pix_valid low: outputs 0 (black), underflow set; pixel position is not retried (raster never stalls).
- underflow clears only on rstin.
- frame_start = active && h_cnt==0 && v_cnt==0, registered.

## Timing
- Reset (rstin high at an edge): h_cnt=v_cnt=0, de=0, hsync=~HS_POL, vsync=~VS_POL, RGB=0, frame_start=0, underflow=0. Reset mid-frame aborts immediately; first post-reset active pixel is (0,0).
- Latency: exactly one cycle from counter state to all outputs; de, hsync, vsync, RGB, frame_start always change on the same edge.
- pix_ready high for H_ACTIVE consecutive cycles per active line, zero in blanking; exactly H_ACTIVE*V_ACTIVE transfers per underflow-free frame.
- Upstream data with pix_valid high while pix_ready low is not consumed and must be held.
- Simultaneous h and v wrap: both counters return to 0 on the same edge.

## Structure
- Package video_timing_pkg: default 720p constants, RGB field offsets, counter width function.
- Sub-module vid_axis_counter (one per axis): counter with wrap, terminal-count output, active and sync-window decode; v instance advances on h terminal count.
- Top holds handshake, output register and underflow flag.

## Test plan
- Small raster H 8/2/3/1 (total 14), V 4/1/2/1 (total 8), HS_POL=VS_POL=1, pix_valid always 1 with incrementing data -> de high 8 cycles per line for lines 0-3, hsync high h_cnt 10-12 (outputs one cycle later), vsync high lines 5-6, 32 transfers per frame, frame period 112 cycles, frame_start once per frame.
- Reset asserted mid-line 2 for 3 cycles -> all outputs at reset values next edge; first de cycle after release carries first new pixel; frame_start pulses.
- pix_valid low for 2 cycles during line 1 -> those two de cycles output RGB 0, underflow goes 1 and stays 1 through next frame; only 30 transfers that frame.
- HS_POL=0, VS_POL=0 -> syncs idle high from reset, low in sync windows; de timing unchanged.
- en dropped mid-frame for 5 cycles -> pix_ready 0, de 0, syncs inactive; on en rise raster restarts at (0,0) with frame_start.
- Default 720p params -> frame period 1650*750 = 1,237,500 cycles, 921,600 transfers.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
package video_timing_pkg;

    // 1280x720@60 timing at a 74.25 MHz pixel clock.
    localparam int unsigned DefHActive = 1280;
    localparam int unsigned DefHFp     = 110;
    localparam int unsigned DefHSync   = 40;
    localparam int unsigned DefHBp     = 220;
    localparam int unsigned DefVActive = 720;
    localparam int unsigned DefVFp     = 5;
    localparam int unsigned DefVSync   = 5;
    localparam int unsigned DefVBp     = 20;

    // Upstream pixel word layout {R, G, B}.
    localparam int unsigned PixWidth = 24;
    localparam int unsigned RedLsb   = 16;
    localparam int unsigned GreenLsb = 8;
    localparam int unsigned BlueLsb  = 0;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    // Bits needed to count 0..total-1 (at least one).
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel stream handshake between the upstream source and the timing generator.
interface video_timing_gen_if;
    import video_timing_pkg::*;

    logic [PixWidth-1:0] pix_data;
    logic                pix_valid;
    logic                pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/vid_axis_counter.sv
// One raster axis: wrapping position counter with active and sync-window decode.
module vid_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned Active     = DefHActive,
    parameter int unsigned FrontPorch = DefHFp,
    parameter int unsigned SyncWidth  = DefHSync,
    parameter int unsigned BackPorch  = DefHBp,
    parameter int unsigned Width      = cnt_width(Active + FrontPorch + SyncWidth + BackPorch)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o,
    output logic             active_o,
    output logic             sync_o
);

    localparam int unsigned Total     = Active + FrontPorch + SyncWidth + BackPorch;
    localparam int unsigned SyncStart = Active + FrontPorch;
    localparam int unsigned SyncEnd   = Active + FrontPorch + SyncWidth;

    logic [Width-1:0] cnt_q, cnt_d;

    // Compares done at 32 bits so a window ending exactly at Total cannot overflow.
    assign tc_o     = (32'(cnt_q) == Total - 1);
    assign active_o = (32'(cnt_q) < Active);
    assign sync_o   = (32'(cnt_q) >= SyncStart) && (32'(cnt_q) < SyncEnd);
    assign cnt_o    = cnt_q;

    // Next position: clear to origin, or advance and wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + Width'(1);
        end
    end

    // Position register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel pacer feeding the TMDS encoder.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic                     pixelclk,
    input  logic                     rstin,
    input  logic                     en,
    video_timing_gen_if.slave        pix,
    output logic [7:0]               red_dout,
    output logic [7:0]               green_dout,
    output logic [7:0]               blue_dout,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     de,
    output logic                     frame_start,
    output logic                     underflow
);

    localparam int unsigned HW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_tc, h_act, h_sync;
    logic          v_tc, v_act, v_sync;
    logic          active;

    vid_axis_counter #(
        .Active     (H_ACTIVE),
        .FrontPorch (H_FP),
        .SyncWidth  (H_SYNC),
        .BackPorch  (H_BP),
        .Width      (HW)
    ) u_h_cnt (
        .clk_i    (pixelclk),
        .rst_i    (rstin),
        .clr_i    (~en),
        .inc_i    (en),
        .cnt_o    (h_cnt),
        .tc_o     (h_tc),
        .active_o (h_act),
        .sync_o   (h_sync)
    );

    // Vertical axis advances once per line, so vsync spans whole lines.
    vid_axis_counter #(
        .Active     (V_ACTIVE),
        .FrontPorch (V_FP),
        .SyncWidth  (V_SYNC),
        .BackPorch  (V_BP),
        .Width      (VW)
    ) u_v_cnt (
        .clk_i    (pixelclk),
        .rst_i    (rstin),
        .clr_i    (~en),
        .inc_i    (en & h_tc),
        .cnt_o    (v_cnt),
        .tc_o     (v_tc),
        .active_o (v_act),
        .sync_o   (v_sync)
    );

    assign active        = en & h_act & v_act;
    assign pix.pix_ready = active;

    rgb_t rgb_q, rgb_d;
    logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, uf_q, uf_d;

    // Output stage next state; a starved active pixel goes out black and is not retried.
    always_comb begin
        de_d  = active;
        hs_d  = (en && h_sync) ? HS_POL : ~HS_POL;
        vs_d  = (en && v_sync) ? VS_POL : ~VS_POL;
        fs_d  = active && (h_cnt == '0) && (v_cnt == '0);
        uf_d  = uf_q | (active & ~pix.pix_valid);
        rgb_d = '0;
        if (active && pix.pix_valid) begin
            rgb_d.red   = pix.pix_data[RedLsb +: 8];
            rgb_d.green = pix.pix_data[GreenLsb +: 8];
            rgb_d.blue  = pix.pix_data[BlueLsb +: 8];
        end
    end

    // All encoder-facing outputs registered together so they stay aligned.
    always_ff @(posedge pixelclk) begin
        if (rstin) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            fs_q  <= 1'b0;
            uf_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
            uf_q  <= uf_d;
            rgb_q <= rgb_d;
        end
    end

    assign red_dout    = rgb_q.red;
    assign green_dout  = rgb_q.green;
    assign blue_dout   = rgb_q.blue;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule
